// File: rtl/fir_pkg.sv
// Shared constants and types for the 4-tap FIR and its inverse (fir_deconv).
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
// Contents: sample width W, filter length NTAPS, tap coefficients, FSM state type.
package fir_pkg;

   localparam int W     = 8;
   localparam int NTAPS = 4;

   // Tap 0 must stay 1 so the inverse filter recovers x exactly.
   // The forward FIR reads the same array, which keeps both ends consistent.
   localparam int unsigned COEFF [NTAPS] = '{1, 2, 3, 4};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/fir_deconv_if.sv
// Valid/ready bundle carrying filtered samples in and recovered samples out.
// Latency: n/a (wiring only).
// Backpressure: standard valid/ready on both the y side and the x side.
// Signals: in_valid/in_ready/y_in (filtered stream), out_valid/out_ready/x_out (recovered stream).
interface fir_deconv_if #(
   parameter int W = 8
) ();

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] y_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] x_out;

   // slave: the deconvolver itself
   modport slave (
      input  in_valid,
      input  y_in,
      input  out_ready,
      output in_ready,
      output out_valid,
      output x_out
   );

   // master: whatever feeds y and consumes x
   modport master (
      output in_valid,
      output y_in,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  x_out
   );

endinterface

// File: rtl/fir_deconv_mac.sv
// One multiply-subtract step of the recursion: res = acc - coeff*hist mod 2^W.
// Latency: combinational.
// Backpressure: none (pure datapath, sequenced by fir_deconv).
// Ports: acc (running value), coeff (tap k), hist (x[n-k]), res (updated value).
module fir_deconv_mac #(
   parameter int W = 8
) (
   input  logic [W-1:0] acc,
   input  logic [W-1:0] coeff,
   input  logic [W-1:0] hist,
   output logic [W-1:0] res
);

   logic [2*W-1:0] prod;

   // Full-width product; only its low W bits can affect a mod-2^W result,
   // so the difference is formed at 2W and truncated in one step.
   assign prod = (2*W)'(coeff) * (2*W)'(hist);
   assign res  = W'({{W{1'b0}}, acc} - prod);

endmodule

// File: rtl/fir_deconv.sv
// Inverse of the 4-tap FIR: x[n] = y[n] - 2x[n-1] - 3x[n-2] - 4x[n-3] mod 2^W.
// Latency: 4 cycles from input handshake to out_valid; min sample period 5 cycles.
// Backpressure: one sample in flight; in_ready stays low until x_out is taken.
// Ports: clk, reset (sync, active-low), bus (fir_deconv_if.slave: y in, x out).
module fir_deconv #(
   parameter int W     = fir_pkg::W,
   parameter int NTAPS = fir_pkg::NTAPS
) (
   input  logic         clk,
   input  logic         reset,
   fir_deconv_if.slave  bus
);

   import fir_pkg::*;

   state_t       state;
   logic [W-1:0] acc;
   logic [1:0]   k;
   logic [W-1:0] hist [1:NTAPS-1];   // hist[i] = x[n-i]
   logic [W-1:0] result;
   logic         result_valid;
   logic         accept_en;          // registered in_ready, depends on state only

   logic [W-1:0] coeff_k;
   logic [W-1:0] hist_k;
   logic [W-1:0] mac_res;

   // Select the tap and history word for the current step.
   always_comb begin
      coeff_k = W'(COEFF[k]);
      hist_k  = '0;
      for (int i = 1; i < NTAPS; i++) begin
         if (k == 2'(i)) hist_k = hist[i];
      end
   end

   fir_deconv_mac #(.W(W)) u_mac (
      .acc   (acc),
      .coeff (coeff_k),
      .hist  (hist_k),
      .res   (mac_res)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= IDLE;
         acc          <= '0;
         k            <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         accept_en    <= 1'b0;
         for (int i = 1; i < NTAPS; i++) hist[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept_en && bus.in_valid) begin
                  acc       <= bus.y_in;   // tap 0 is 1, so y seeds the accumulator
                  k         <= 2'd1;
                  accept_en <= 1'b0;
                  state     <= MAC;
               end else begin
                  accept_en <= 1'b1;       // first cycle after reset release
               end
            end

            MAC: begin
               acc <= mac_res;
               if (k == 2'(NTAPS - 1)) begin
                  // History advances here, not on the output handshake, so a
                  // stalled consumer never disturbs the recursion.
                  result       <= mac_res;
                  result_valid <= 1'b1;
                  hist[1]      <= mac_res;
                  for (int i = 2; i < NTAPS; i++) hist[i] <= hist[i-1];
                  k            <= '0;
                  state        <= HOLD;
               end else begin
                  k <= k + 2'd1;
               end
            end

            HOLD: begin
               if (bus.out_ready) begin
                  result_valid <= 1'b0;
                  accept_en    <= 1'b1;
                  state        <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = accept_en;
   assign bus.out_valid = result_valid;
   assign bus.x_out     = result;

endmodule

// File: tb/tb_fir_deconv.sv
// Scoreboard bench for fir_deconv: directed vectors plus a random round trip.
// Expected x values are queued at stimulus time; a negedge monitor pops them.
module tb_fir_deconv;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fir_deconv_if #(.W(8)) bus ();

   fir_deconv #(.W(8), .NTAPS(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int passes = 0;
   int cyc    = 0;
   int n_in   = 0;
   int n_out  = 0;

   logic [7:0] exp_q [$];
   int         lat_q [$];
   logic       prev_ov = 1'b0;
   bit         mon_en  = 1'b0;
   bit         rt_done = 1'b0;

   logic [7:0] m1, m2, m3;   // reference FIR delay line

   logic [7:0] imp_y  [6] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0};
   logic [7:0] imp_x  [6] = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
   logic [7:0] wrap_y [4] = '{8'd200, 8'd144, 8'd88, 8'd32};
   logic [7:0] wrap_x [4] = '{8'd200, 8'd0, 8'd0, 8'd0};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic timeout(input string name);
      checks++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   // Monitor: latency on each out_valid rise, data on each output handshake.
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.out_valid && !prev_ov && lat_q.size() > 0)
            check("latency", cyc - lat_q.pop_front(), 4);
         if (bus.out_valid && bus.out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_output: got %0d, expected none", bus.x_out);
            end else begin
               check("x_out", int'(bus.x_out), int'(exp_q.pop_front()));
            end
         end
      end
      prev_ov = bus.out_valid;
   end

   // Present y and hold it until accepted. Called just after a rising edge.
   task automatic send(input logic [7:0] y, input bit track);
      int n = 0;
      bus.y_in     = y;
      bus.in_valid = 1'b1;
      if (track) n_in++;
      @(negedge clk);
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) timeout("in_ready_wait");
      else if (track) lat_q.push_back(cyc);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         timeout("drain");
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      reset         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.y_in      = '0;
      bus.out_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_x_out", bus.x_out, 0);
      check("rst_in_ready", bus.in_ready, 0);
      @(posedge clk);
      #1;
      reset  = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("in_ready_after_reset", bus.in_ready, 1);
      @(posedge clk);
      #1;

      // Impulse
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(imp_x[i]);
         send(imp_y[i], 1'b1);
      end
      drain();

      // Wrap-around
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(wrap_x[i]);
         send(wrap_y[i], 1'b1);
      end
      drain();

      // Backpressure: history is all zero, so y=9 gives x=9
      bus.out_ready = 1'b0;
      exp_q.push_back(8'd9);
      send(8'd9, 1'b1);
      n = 0;
      @(negedge clk);
      while (!bus.out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.out_valid) timeout("bp_out_valid");
      for (int i = 0; i < 10; i++) begin
         check("bp_x_stable", bus.x_out, 9);
         check("bp_valid_stable", bus.out_valid, 1);
         check("bp_in_ready_low", bus.in_ready, 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_in_ready_after", bus.in_ready, 1);
      check("bp_out_valid_after", bus.out_valid, 0);
      @(posedge clk);
      #1;
      // x[n-1]=9: y = 5 + 2*9 = 23 -> x = 5
      exp_q.push_back(8'd5);
      send(8'd23, 1'b1);
      drain();

      // Reset during the second MAC cycle discards the sample and history
      send(8'd50, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_out_valid", bus.out_valid, 0);
      @(negedge clk);
      check("mid_rst_in_ready", bus.in_ready, 1);
      @(posedge clk);
      #1;
      exp_q.push_back(8'd7);
      send(8'd7, 1'b1);
      drain();

      // Round trip through a reference FIR; DUT history is now {7, 0, 0}
      m1 = 8'd7;
      m2 = 8'd0;
      m3 = 8'd0;
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               logic [7:0] x;
               logic [7:0] y;
               int gap;
               x = 8'($urandom_range(0, 255));
               y = 8'(int'(x) + 2 * int'(m1) + 3 * int'(m2) + 4 * int'(m3));
               m3 = m2;
               m2 = m1;
               m1 = x;
               exp_q.push_back(x);
               send(y, 1'b1);
               gap = $urandom_range(0, 3);
               repeat (gap) @(posedge clk);
               #1;
            end
            drain();
            rt_done = 1'b1;
         end
         begin
            while (!rt_done) begin
               @(posedge clk);
               #1;
               if (!rt_done) bus.out_ready = ($urandom_range(0, 3) != 0);
            end
            bus.out_ready = 1'b1;
         end
      join

      check("output_count", n_out, n_in);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
